cache_axi_rd_bridge: RTL and testbench

- Read-side responder for the cache refill interface (rd_req/rd_type/rd_addr/rd_rdy/ret_*).
- Converts one cache read request into one AXI4 read burst (AR then R) and streams the returned words back as ret_valid/ret_data/ret_last.
- Sits between the icache/dcache miss logic and the SoC AXI interconnect.
- One outstanding transaction; no write channel.

---
 rtl/cache_axi_rd_bridge_pkg.sv | 39 +++
 rtl/cache_axi_rd_bridge.sv | 153 +++++++++++++++
 tb/tb_cache_axi_rd_bridge.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_rd_bridge_pkg.sv
// Shared definitions for the cache refill read bridge: request type codes,
// AXI4 read-channel constants, FSM state encoding and request decode helpers.
package cache_axi_rd_bridge_pkg;

  localparam logic [2:0] RD_BYTE = 3'b000;
  localparam logic [2:0] RD_HALF = 3'b001;
  localparam logic [2:0] RD_WORD = 3'b010;
  localparam logic [2:0] RD_LINE = 3'b100;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_1     = 3'd0;
  localparam logic [2:0] SIZE_2     = 3'd1;
  localparam logic [2:0] SIZE_4     = 3'd2;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_e;

  // Beats minus one: a line is four words, everything else a single beat.
  function automatic logic [1:0] type_len(input logic [2:0] rd_type);
    return (rd_type == RD_LINE) ? 2'd3 : 2'd0;
  endfunction

  // Reserved encodings fall through to a full word access.
  function automatic logic [2:0] type_size(input logic [2:0] rd_type);
    logic [2:0] size;
    case (rd_type)
      RD_BYTE:          size = SIZE_1;
      RD_HALF:          size = SIZE_2;
      RD_WORD, RD_LINE: size = SIZE_4;
      default:          size = SIZE_4;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/cache_axi_rd_bridge.sv
// Cache refill read bridge: one cache read request becomes one AXI4 read burst.
// Define CACHE_AXI_RD_RET_REG_EN to register the ret_* outputs (+1 cycle per word).
module cache_axi_rd_bridge
  import cache_axi_rd_bridge_pkg::*;
#(
  parameter int AXI_ID   = 0,
  parameter int ID_WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                rd_req,
  input  logic [2:0]          rd_type,
  input  logic [31:0]         rd_addr,
  output logic                rd_rdy,
  output logic                ret_valid,
  output logic                ret_last,
  output logic [31:0]         ret_data,

  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,

  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,

  output logic                resp_err
);

  state_e      r_state;
  logic        r_rd_rdy;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_resp_err;
  logic [31:0] r_araddr;
  logic [7:0]  r_arlen;
  logic [2:0]  r_arsize;
  logic [1:0]  r_len;
  logic [1:0]  r_beat_cnt;

  logic        w_beat;
  logic        w_last_beat;
  logic        w_beat_err;
  logic        w_unused_rid;

  // rready is only ever high in R; masking with reset drops a beat in the reset cycle.
  assign w_beat      = r_rready & rvalid & ~reset;
  assign w_last_beat = (r_beat_cnt == r_len);
  assign w_beat_err  = (rresp != RESP_OKAY) | (rlast != w_last_beat);
  assign w_unused_rid = ^rid;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rd_rdy   <= 1'b1;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_resp_err <= 1'b0;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_arsize   <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rd_req) begin
            r_araddr   <= rd_addr;
            r_arlen    <= {6'd0, type_len(rd_type)};
            r_arsize   <= type_size(rd_type);
            r_len      <= type_len(rd_type);
            r_beat_cnt <= 2'd0;
            r_arvalid  <= 1'b1;
            r_rd_rdy   <= 1'b0;
            r_state    <= S_AR;
          end
        end
        S_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 2'd1;
            if (w_beat_err) r_resp_err <= 1'b1;
            // Termination follows the local beat count, never the slave's rlast.
            if (w_last_beat) begin
              r_rready <= 1'b0;
              r_rd_rdy <= 1'b1;
              r_state  <= S_IDLE;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_rd_rdy  <= 1'b1;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_AXI_RD_RET_REG_EN
  logic        r_ret_valid;
  logic        r_ret_last;
  logic [31:0] r_ret_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ret_valid <= 1'b0;
      r_ret_last  <= 1'b0;
      r_ret_data  <= '0;
    end else begin
      r_ret_valid <= w_beat;
      r_ret_last  <= w_beat & w_last_beat;
      r_ret_data  <= w_beat ? rdata : '0;
    end
  end

  assign ret_valid = r_ret_valid;
  assign ret_last  = r_ret_last;
  assign ret_data  = r_ret_data;
`else
  assign ret_valid = w_beat;
  assign ret_last  = w_beat & w_last_beat;
  assign ret_data  = w_beat ? rdata : '0;
`endif

  assign rd_rdy   = r_rd_rdy;
  assign arid     = ID_WIDTH'(AXI_ID);
  assign araddr   = r_araddr;
  assign arlen    = r_arlen;
  assign arsize   = r_arsize;
  assign arburst  = BURST_INCR;
  assign arvalid  = r_arvalid;
  assign rready   = r_rready;
  assign resp_err = r_resp_err;

endmodule

// File: tb/tb_cache_axi_rd_bridge.sv
// Scoreboard bench for cache_axi_rd_bridge; honours CACHE_AXI_RD_RET_REG_EN for return latency.
module tb_cache_axi_rd_bridge;
  import cache_axi_rd_bridge_pkg::*;

  localparam int IDW = 4;
`ifdef CACHE_AXI_RD_RET_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic           clock, reset;
  logic           rd_req, rd_rdy, ret_valid, ret_last;
  logic [2:0]     rd_type;
  logic [31:0]    rd_addr, ret_data, araddr, rdata;
  logic [IDW-1:0] arid, rid;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst, rresp;
  logic           arvalid, arready, rlast, rvalid, rready, resp_err;

  cache_axi_rd_bridge #(.AXI_ID(0), .ID_WIDTH(IDW)) dut (
    .clock(clock), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .resp_err(resp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit exp_err = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ret_valid must match the oldest expected word, in the expected cycle.
  always @(negedge clock) begin
    if (ret_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_ret_valid", ret_valid, 0);
      end else begin
        e = sb.pop_front();
        check("ret_data", ret_data, e.data);
        check("ret_last", ret_last, e.last);
        check("ret_cycle", cyc, e.cyc);
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      check("ret_missing", 0, 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic apply_reset();
    reset = 1'b1; rd_req = 1'b0; rvalid = 1'b0; arready = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rst_rd_rdy", rd_rdy, 1);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_ret_valid", ret_valid, 0);
    check("rst_ret_last", ret_last, 0);
    check("rst_ret_data", ret_data, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_arsize", arsize, 0);
    check("rst_resp_err", resp_err, 0);
    reset = 1'b0;
    exp_err = 1'b0;
    @(posedge clock); #1;
    check("post_rst_rd_rdy", rd_rdy, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rvalid = 1'($urandom); rdata = $urandom; rlast = 1'($urandom); rresp = 2'($urandom);
      @(posedge clock); #1;
    end
    rvalid = 1'b0;
  endtask

  // One request end to end; the bench also plays the AXI slave.
  // gap < 0 picks a random gap per beat; beat indices are 0-based; -1 disables an option.
  task automatic run_txn(input logic [2:0] typ, input logic [31:0] addr, input int ar_dly,
                         input int gap, input int bad_resp_beat, input int bad_last_beat,
                         input int abort_after);
    int          beats;
    int          g;
    logic [2:0]  esize;
    bit          lst;
    beats = (typ == 3'b100) ? 4 : 1;
    esize = (typ == 3'b000) ? 3'd0 : (typ == 3'b001) ? 3'd1 : 3'd2;

    check("rd_rdy_idle", rd_rdy, 1);
    rd_req = 1'b1; rd_type = typ; rd_addr = addr;
    @(posedge clock); #1;
    rd_req = 1'b0; rd_type = 3'($urandom); rd_addr = $urandom;
    check("rd_rdy_busy", rd_rdy, 0);

    for (int i = 0; i <= ar_dly; i++) begin
      arready = (i == ar_dly);
      rvalid = 1'($urandom); rdata = $urandom; rlast = 1'($urandom); rresp = 2'($urandom);
      check("arvalid", arvalid, 1);
      check("araddr", araddr, addr);
      check("arlen", arlen, beats - 1);
      check("arsize", arsize, esize);
      check("arburst", arburst, 2'b01);
      check("arid", arid, 0);
      @(posedge clock); #1;
    end
    arready = 1'b0; rvalid = 1'b0;
    check("arvalid_drop", arvalid, 0);

    for (int b = 0; b < beats; b++) begin
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      for (int k = 0; k < g; k++) begin
        @(posedge clock); #1;
      end
      lst   = (b == beats - 1);
      rvalid = 1'b1;
      rdata  = $urandom;
      rid    = 4'($urandom);
      rresp  = (b == bad_resp_beat) ? 2'b10 : 2'b00;
      rlast  = (b == bad_last_beat) ? !lst : lst;
      if (rresp != 2'b00 || rlast != lst) exp_err = 1'b1;
      sb.push_back('{data: rdata, last: lst, cyc: cyc + LAT});
      check("rready", rready, 1);
      @(posedge clock); #1;
      rvalid = 1'b0;
      check("resp_err_beat", resp_err, exp_err);
      if (abort_after == b + 1) begin
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_err = 1'b0;
        check("abort_rd_rdy", rd_rdy, 1);
        check("abort_rready", rready, 0);
        check("abort_arvalid", arvalid, 0);
        check("abort_resp_err", resp_err, 0);
        rvalid = 1'b1; rdata = $urandom; rlast = 1'b1; rresp = 2'b00;
        @(posedge clock); #1;
        rvalid = 1'b0;
        return;
      end
    end
    check("rd_rdy_after", rd_rdy, 1);
    check("rready_after", rready, 0);
    check("resp_err_end", resp_err, exp_err);
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; rd_type = 3'b000; rd_addr = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    apply_reset();

    run_txn(RD_LINE, 32'h1C00_0010, 0, 0, -1, -1, -1);
    idle(1);
    run_txn(RD_BYTE, 32'h8000_0003, 3, 0, -1, -1, -1);
    run_txn(RD_LINE, 32'h1C00_0040, 1, 2, -1, -1, -1);
    run_txn(RD_LINE, 32'h1C00_0080, 0, 0, 2, -1, -1);
    run_txn(RD_WORD, 32'h0000_1234, 0, 0, -1, -1, -1);
    apply_reset();
    run_txn(RD_LINE, 32'h1C00_00C0, 0, 0, -1, 0, -1);
    apply_reset();
    run_txn(RD_LINE, 32'h2000_0000, 0, 0, 0, -1, 2);
    run_txn(RD_WORD, 32'h2000_0100, 0, 0, -1, -1, -1);
    run_txn(RD_HALF, 32'h2000_0102, 2, 0, -1, -1, -1);
    run_txn(3'b111, 32'h2000_0200, 0, 0, -1, -1, -1);
    run_txn(RD_LINE, 32'h2000_0300, 0, 0, -1, -1, -1);
    run_txn(RD_WORD, 32'h2000_0400, 0, 0, -1, -1, -1);

    for (int t = 0; t < 60; t++) begin
      logic [2:0] typ;
      int         nb;
      if (t % 15 == 0) apply_reset();
      typ = ($urandom_range(0, 1) == 0) ? RD_LINE : 3'($urandom);
      nb  = (typ == 3'b100) ? 4 : 1;
      run_txn(typ, $urandom, $urandom_range(0, 3), -1,
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, nb - 1) : -1,
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, nb - 1) : -1,
              -1);
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
